// File: rtl/ptx_lane_if.sv
// ptx_lane_if
//   Bundles the four lane-side valid/ready/data handshakes and the registered
//   byte stream toward the serializer.
//   Lane side     : data_0p..data_3p, valid_0p..valid_3p in; ready_0..ready_3 out.
//   Serializer    : data_out, valid_out, lane_out, idle_out, sync_done out.
//   Modports      : slave  - the scheduler.
//                   master - lane sources and serializer (the environment).
interface ptx_lane_if;
  logic [7:0] data_0p, data_1p, data_2p, data_3p;
  logic       valid_0p, valid_1p, valid_2p, valid_3p;
  logic       ready_0, ready_1, ready_2, ready_3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       idle_out;
  logic       sync_done;

  modport slave (
    input  data_0p, data_1p, data_2p, data_3p,
    input  valid_0p, valid_1p, valid_2p, valid_3p,
    output ready_0, ready_1, ready_2, ready_3,
    output data_out, valid_out, lane_out, idle_out, sync_done
  );

  modport master (
    output data_0p, data_1p, data_2p, data_3p,
    output valid_0p, valid_1p, valid_2p, valid_3p,
    input  ready_0, ready_1, ready_2, ready_3,
    input  data_out, valid_out, lane_out, idle_out, sync_done
  );
endinterface

// File: rtl/ptx_lane_scheduler.sv
// ptx_lane_scheduler
//   Transmit-side controller for the four-lane parallel-to-serial path.
//   After reset it sends SYNC_COUNT comma bytes, then shares the single byte
//   slot feeding the serializer among lanes 0..3 with round-robin arbitration.
//   Comma fill is emitted whenever no lane transfers; idle_out flags a run of
//   IDLE_THRESH or more no-transfer cycles.
//   Ports:
//     clk_4f : byte-rate clock, rising edge
//     reset  : synchronous, active-high
//     bus    : ptx_lane_if.slave (lane handshakes in, serializer byte out)
module ptx_lane_scheduler #(
  parameter int         SYNC_COUNT  = 16,
  parameter int         IDLE_THRESH = 4,
  parameter logic [7:0] COMMA       = 8'hBC
) (
  input logic       clk_4f,
  input logic       reset,
  ptx_lane_if.slave bus
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);
  localparam logic [7:0] THRESH    = 8'(IDLE_THRESH);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t     state;
  logic [7:0] sync_cnt;
  logic [7:0] idle_cnt;
  logic [1:0] rr_ptr;

  logic [7:0] lane_data [4];
  logic [3:0] lane_valid;
  logic [3:0] ready;
  logic [1:0] grant_lane;
  logic       xfer;
  logic [7:0] idle_next;

  assign lane_data[0] = bus.data_0p;
  assign lane_data[1] = bus.data_1p;
  assign lane_data[2] = bus.data_2p;
  assign lane_data[3] = bus.data_3p;
  assign lane_valid   = {bus.valid_3p, bus.valid_2p, bus.valid_1p, bus.valid_0p};

  assign bus.ready_0 = ready[0];
  assign bus.ready_1 = ready[1];
  assign bus.ready_2 = ready[2];
  assign bus.ready_3 = ready[3];

  // Round-robin search starting one past the last granted lane. Since ready
  // is only raised on a valid lane, "a ready is high" already means a transfer.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    ready      = '0;
    grant_lane = rr_ptr;
    xfer       = 1'b0;
    idx        = '0;
    if (state == ACTIVE) begin
      for (int i = 1; i <= 4; i++) begin
        idx = rr_ptr + 2'(i);
        if (!xfer && lane_valid[idx]) begin
          xfer       = 1'b1;
          ready[idx] = 1'b1;
          grant_lane = idx;
        end
      end
    end
  end

  assign idle_next = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state         <= SYNC;
      sync_cnt      <= '0;
      rr_ptr        <= 2'd3;
      idle_cnt      <= '0;
      bus.data_out  <= COMMA;
      bus.valid_out <= 1'b0;
      bus.lane_out  <= '0;
      bus.idle_out  <= 1'b1;
      bus.sync_done <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          bus.data_out  <= COMMA;
          bus.valid_out <= 1'b0;
          bus.lane_out  <= '0;
          bus.idle_out  <= 1'b1;
          sync_cnt      <= sync_cnt + 8'd1;
          if (sync_cnt == SYNC_LAST) begin
            state         <= ACTIVE;
            bus.sync_done <= 1'b1;
          end
        end
        ACTIVE: begin
          bus.sync_done <= 1'b1;
          if (xfer) begin
            bus.data_out  <= lane_data[grant_lane];
            bus.valid_out <= 1'b1;
            bus.lane_out  <= grant_lane;
            rr_ptr        <= grant_lane;
            idle_cnt      <= '0;
            bus.idle_out  <= 1'b0;
          end else begin
            bus.data_out  <= COMMA;
            bus.valid_out <= 1'b0;
            bus.lane_out  <= '0;
            idle_cnt      <= idle_next;
            bus.idle_out  <= (idle_next >= THRESH);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ptx_lane_scheduler.sv
// tb_ptx_lane_scheduler
//   Directed bench for ptx_lane_scheduler with default parameters
//   (SYNC_COUNT=16, IDLE_THRESH=4, COMMA=8'hBC).
module tb_ptx_lane_scheduler;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ptx_lane_if bus ();

  ptx_lane_scheduler dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic set_valids(input logic [3:0] v);
    bus.valid_0p = v[0];
    bus.valid_1p = v[1];
    bus.valid_2p = v[2];
    bus.valid_3p = v[3];
  endtask

  function automatic logic [3:0] ready_vec();
    return {bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};
  endfunction

  task automatic check_comma(input string tag, input logic exp_idle);
    check({tag, "_data"},  bus.data_out,  8'hBC);
    check({tag, "_valid"}, bus.valid_out, 1'b0);
    check({tag, "_lane"},  bus.lane_out,  2'd0);
    check({tag, "_idle"},  bus.idle_out,  exp_idle);
  endtask

  task automatic check_xfer(input string tag, input logic [1:0] lane, input logic [7:0] data);
    check({tag, "_valid"}, bus.valid_out, 1'b1);
    check({tag, "_lane"},  bus.lane_out,  lane);
    check({tag, "_data"},  bus.data_out,  data);
    check({tag, "_idle"},  bus.idle_out,  1'b0);
  endtask

  // Reset release with all valids high: 16 comma cycles, then lane 0 first.
  task automatic sync_phase(input string tag);
    for (int c = 1; c <= 16; c++) begin
      tick();
      check_comma({tag, "_sync"}, 1'b1);
      check({tag, "_sync_done"}, bus.sync_done, (c == 16));
      check({tag, "_sync_ready"}, ready_vec(), (c == 16) ? 4'b0001 : 4'b0000);
    end
    tick();
    check_xfer({tag, "_first"}, 2'd0, 8'h10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_0p = 8'h10;
    bus.data_1p = 8'h11;
    bus.data_2p = 8'h12;
    bus.data_3p = 8'h13;
    set_valids(4'b1111);

    // Reset state
    tick();
    tick();
    check_comma("rst", 1'b1);
    check("rst_sync_done", bus.sync_done, 1'b0);
    check("rst_ready", ready_vec(), 4'b0000);

    reset = 1'b0;
    sync_phase("init");

    // All four valid: grants continue 1,2,3,0,1 after the first lane 0
    for (int k = 1; k <= 5; k++) begin
      check("rr_ready_onehot", $countones(ready_vec()), 1);
      tick();
      check_xfer("rr", 2'(k), 8'h10 + 8'(k % 4));
    end

    // Only lane 2 valid with A5 (rr_ptr is now 1)
    set_valids(4'b0100);
    bus.data_2p = 8'hA5;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("solo_ready", ready_vec(), 4'b0100);
      tick();
      check_xfer("solo", 2'd2, 8'hA5);
    end

    // Lane 0 joins: grants alternate 0,2,0,2
    set_valids(4'b0101);
    #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) check_xfer("alt", 2'd0, 8'h10);
      else            check_xfer("alt", 2'd2, 8'hA5);
    end

    // Idle run: idle_out rises on the 4th no-transfer edge
    set_valids(4'b0000);
    #1;
    check("idle_ready", ready_vec(), 4'b0000);
    for (int n = 1; n <= 6; n++) begin
      tick();
      check_comma("idle", (n >= 4));
    end
    set_valids(4'b1000);
    tick();
    check_xfer("idle_exit", 2'd3, 8'h13);
    set_valids(4'b0000);

    // Lane 1 drops valid in its grant cycle while lane 3 is valid (rr_ptr=3)
    set_valids(4'b1010);
    #1;
    check("drop_ready_pre", ready_vec(), 4'b0010);
    bus.valid_1p = 1'b0;
    #1;
    check("drop_ready_post", ready_vec(), 4'b1000);
    tick();
    check_xfer("drop", 2'd3, 8'h13);
    set_valids(4'b0000);
    tick();
    check_comma("drop_after", 1'b0);

    // Reset during a lane 1 grant (rr_ptr=3): transfer is dropped, SYNC repeats
    set_valids(4'b0010);
    #1;
    check("mid_ready", ready_vec(), 4'b0010);
    reset = 1'b1;
    tick();
    check_comma("mid_rst", 1'b1);
    check("mid_rst_sync_done", bus.sync_done, 1'b0);
    reset = 1'b0;
    set_valids(4'b1111);
    sync_phase("resync");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
